ram_frame_writer: RTL and testbench

RAM_FRAME_WRITER -- requirements
Module: ram_frame_writer

---
 rtl/ram_frame_pkg.sv | 30 +++
 rtl/ram_frame_writer.sv | 186 ++++++++++++++++++
 tb/tb_ram_frame_writer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_frame_pkg.sv
// rtl/ram_frame_pkg.sv - shared types for the RAM frame writer
//
// Purpose: FSM state encoding, frame descriptor struct and a small
//          saturating-counter helper used by ram_frame_writer.
// Ports:   none (package).

package ram_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_DROP   = 2'd2,
    ST_COMMIT = 2'd3
  } frame_state_t;

  // Fixed-width container wide enough for any supported AW/LW; the writer
  // zero-extends its narrower fields into it.
  localparam int DESC_ADDR_W = 16;
  localparam int DESC_LEN_W  = 17;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] addr;
    logic [DESC_LEN_W-1:0]  len;
  } frame_desc_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ram_frame_writer.sv
// rtl/ram_frame_writer.sv - writes framed word stream into a circular RAM buffer
//
// Purpose: accepts a valid/ready word stream, writes each kept word to the
//          RAM write port one cycle after acceptance, and publishes a
//          {addr,len} descriptor per complete frame. Frames that overflow the
//          buffer or exceed MAX_LEN are rolled back and discarded.
// Optional: FRAME_DROP_CNT_EN adds the saturating drop_cnt output.
// Ports:
//   clka, rstb              clock, synchronous active-high reset
//   s_data/s_valid/s_last   word stream in, s_ready back-pressure out
//   rd_free_ptr             reader release pointer (AW+1 bits, clka domain)
//   wea/addra/dina          RAM port A write
//   desc_valid/desc_ready   descriptor handshake, desc_addr/desc_len payload
//   drop_cnt                dropped-frame count (FRAME_DROP_CNT_EN only)

module ram_frame_writer
  import ram_frame_pkg::*;
#(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 1024,
  parameter int MAX_LEN   = 256,
  localparam int AW = $clog2(RAM_DEPTH),
  localparam int LW = $clog2(MAX_LEN) + 1
) (
  input  logic                 clka,
  input  logic                 rstb,
  input  logic [RAM_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  input  logic [AW:0]          rd_free_ptr,
  output logic                 wea,
  output logic [AW-1:0]        addra,
  output logic [RAM_WIDTH-1:0] dina,
  output logic                 desc_valid,
  input  logic                 desc_ready,
  output logic [AW-1:0]        desc_addr,
  output logic [LW-1:0]        desc_len
`ifdef FRAME_DROP_CNT_EN
  ,
  output logic [15:0]          drop_cnt
`endif
);

  frame_state_t         r_state;
  frame_state_t         w_state_n;
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_cur_ptr;
  logic [AW:0]          w_wr_ptr_n;
  logic [AW:0]          w_cur_ptr_n;
  logic [LW-1:0]        r_len;
  logic [LW-1:0]        w_len_n;
  logic                 r_wea;
  logic [AW-1:0]        r_addra;
  logic [RAM_WIDTH-1:0] r_dina;

  logic [AW:0]          w_used;
  logic                 w_full;
  logic                 w_len_max;
  logic                 w_accept;
  logic                 w_keep;
  logic                 w_drop;
  frame_desc_t          w_desc;
  logic                 w_unused_desc;

  // Occupancy uses the live rd_free_ptr so a same-cycle release counts.
  assign w_used    = r_cur_ptr - rd_free_ptr;
  assign w_full    = (w_used == (AW+1)'(RAM_DEPTH));
  assign w_len_max = (r_len == LW'(MAX_LEN));

  assign s_ready  = !rstb && (r_state != ST_COMMIT);
  assign w_accept = s_valid && s_ready;

  always_comb begin
    w_state_n   = r_state;
    w_wr_ptr_n  = r_wr_ptr;
    w_cur_ptr_n = r_cur_ptr;
    w_len_n     = r_len;
    w_keep      = 1'b0;
    w_drop      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_full) begin
            w_drop    = 1'b1;
            w_state_n = s_last ? ST_IDLE : ST_DROP;
          end else begin
            w_keep      = 1'b1;
            w_len_n     = LW'(1);
            w_cur_ptr_n = r_cur_ptr + 1'b1;
            w_state_n   = s_last ? ST_COMMIT : ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (w_accept) begin
          if (w_full || w_len_max) begin
            w_drop    = 1'b1;
            w_state_n = s_last ? ST_IDLE : ST_DROP;
          end else begin
            w_keep      = 1'b1;
            w_len_n     = r_len + LW'(1);
            w_cur_ptr_n = r_cur_ptr + 1'b1;
            if (s_last) begin
              w_state_n = ST_COMMIT;
            end
          end
        end
      end
      ST_DROP: begin
        if (w_accept && s_last) begin
          w_state_n = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        if (desc_ready) begin
          w_wr_ptr_n = r_cur_ptr;
          w_len_n    = '0;
          w_state_n  = ST_IDLE;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    // Rollback: words already written for this frame are abandoned in place.
    if (w_drop) begin
      w_cur_ptr_n = r_wr_ptr;
      w_len_n     = '0;
    end
  end

  always_ff @(posedge clka) begin
    if (rstb) begin
      r_state   <= ST_IDLE;
      r_wr_ptr  <= '0;
      r_cur_ptr <= '0;
      r_len     <= '0;
      r_wea     <= 1'b0;
      r_addra   <= '0;
      r_dina    <= '0;
    end else begin
      r_state   <= w_state_n;
      r_wr_ptr  <= w_wr_ptr_n;
      r_cur_ptr <= w_cur_ptr_n;
      r_len     <= w_len_n;
      r_wea     <= w_keep;
      if (w_keep) begin
        r_addra <= r_cur_ptr[AW-1:0];
        r_dina  <= s_data;
      end
    end
  end

  assign wea   = r_wea;
  assign addra = r_addra;
  assign dina  = r_dina;

  // In COMMIT wr_ptr still marks the frame start and len its word count.
  // COMMIT is entered on the same edge that registers the last write, so
  // desc_valid and that wea rise together.
  assign w_desc.addr   = DESC_ADDR_W'(r_wr_ptr[AW-1:0]);
  assign w_desc.len    = DESC_LEN_W'(r_len);
  assign desc_valid    = (r_state == ST_COMMIT);
  assign desc_addr     = w_desc.addr[AW-1:0];
  assign desc_len      = w_desc.len[LW-1:0];
  // Upper struct bits beyond AW/LW are always zero.
  assign w_unused_desc = ^w_desc;

`ifdef FRAME_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clka) begin
    if (rstb) begin
      r_drop_cnt <= 16'd0;
    end else if (w_drop) begin
      r_drop_cnt <= sat_inc16(r_drop_cnt);
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_ram_frame_writer.sv
// tb/tb_ram_frame_writer.sv - self-checking bench for ram_frame_writer

module tb_ram_frame_writer;

  localparam int RW = 32;
  localparam int RD = 16;
  localparam int ML = 8;
  localparam int AW = 4;
  localparam int LW = 4;

  logic          clka;
  logic          rstb;
  logic [RW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [AW:0]   rd_free_ptr;
  logic          wea;
  logic [AW-1:0] addra;
  logic [RW-1:0] dina;
  logic          desc_valid;
  logic          desc_ready;
  logic [AW-1:0] desc_addr;
  logic [LW-1:0] desc_len;
`ifdef FRAME_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  ram_frame_writer #(
    .RAM_WIDTH(RW),
    .RAM_DEPTH(RD),
    .MAX_LEN  (ML)
  ) dut (
    .clka       (clka),
    .rstb       (rstb),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .rd_free_ptr(rd_free_ptr),
    .wea        (wea),
    .addra      (addra),
    .dina       (dina),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_addr  (desc_addr),
    .desc_len   (desc_len)
`ifdef FRAME_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Captured DUT activity
  logic [AW-1:0] cap_addr[$];
  logic [RW-1:0] cap_data[$];
  logic [AW-1:0] cap_daddr[$];
  logic [LW-1:0] cap_dlen[$];

  // Reference model: committed pointer, reader pointer, dropped frames
  int m_wr;
  int m_rd;
  int m_drops;
  bit rdy_auto;
  bit gaps;

  initial begin
    logic prev_dv;
    prev_dv = 1'b0;
    forever begin
      @(negedge clka);
      if (wea) begin
        cap_addr.push_back(addra);
        cap_data.push_back(dina);
      end
      if (desc_valid && !prev_dv) check("dv_rise_with_wea", 64'(wea), 64'd1);
      if (desc_valid && desc_ready) begin
        cap_daddr.push_back(desc_addr);
        cap_dlen.push_back(desc_len);
      end
      prev_dv = desc_valid;
    end
  end

  initial begin
    desc_ready = 1'b0;
    forever begin
      @(posedge clka);
      #1;
      if (rdy_auto) desc_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic clear_caps();
    cap_addr.delete();
    cap_data.delete();
    cap_daddr.delete();
    cap_dlen.delete();
  endtask

  task automatic do_reset();
    rstb        = 1'b1;
    s_valid     = 1'b0;
    s_last      = 1'b0;
    s_data      = '0;
    rd_free_ptr = '0;
    repeat (2) begin
      @(posedge clka);
      #1;
    end
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_wea", 64'(wea), 64'd0);
    check("rst_addra", 64'(addra), 64'd0);
    check("rst_dina", 64'(dina), 64'd0);
    check("rst_desc_valid", 64'(desc_valid), 64'd0);
    check("rst_desc_addr", 64'(desc_addr), 64'd0);
    check("rst_desc_len", 64'(desc_len), 64'd0);
`ifdef FRAME_DROP_CNT_EN
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    rstb = 1'b0;
    #1;
    check("post_rst_s_ready", 64'(s_ready), 64'd1);
    m_wr    = 0;
    m_rd    = 0;
    m_drops = 0;
  endtask

  task automatic send_beat(input logic [RW-1:0] d, input logic last);
    bit acc;
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clka);
        #1;
      end
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 100) begin
      @(negedge clka);
      acc = s_ready;
      @(posedge clka);
      #1;
      t++;
    end
    if (!acc) check("beat_accept_timeout", 64'd0, 64'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Expected outcome derived from buffer space and frame length only:
  // leading words are written while space and MAX_LEN allow; the frame is
  // committed only if the whole of it fits.
  task automatic run_frame(input int n, input logic [RW-1:0] base);
    logic [RW-1:0] d[$];
    logic [RW-1:0] v;
    int used;
    int free;
    int nw;
    int t;
    bit keep;
    used = (m_wr - m_rd) & 31;
    free = RD - used;
    nw   = n;
    if (nw > ML) nw = ML;
    if (nw > free) nw = free;
    keep = (n <= ML) && (n <= free);
    clear_caps();
    for (int i = 0; i < n; i++) begin
      v = (base != 0) ? base + RW'(i) : RW'($urandom());
      d.push_back(v);
      send_beat(v, i == n - 1);
    end
    if (keep) begin
      t = 0;
      while (cap_daddr.size() == 0 && t < 80) begin
        @(posedge clka);
        #1;
        t++;
      end
    end else begin
      repeat (4) begin
        @(posedge clka);
        #1;
      end
    end
    check("wr_count", 64'(cap_addr.size()), 64'(nw));
    for (int i = 0; i < nw && i < cap_addr.size(); i++) begin
      check("wr_addr", 64'(cap_addr[i]), 64'((m_wr + i) & 15));
      check("wr_data", 64'(cap_data[i]), 64'(d[i]));
    end
    check("desc_count", 64'(cap_daddr.size()), 64'(keep));
    if (keep && cap_daddr.size() > 0) begin
      check("desc_addr", 64'(cap_daddr[0]), 64'(m_wr & 15));
      check("desc_len", 64'(cap_dlen[0]), 64'(n));
    end
    if (keep) m_wr = (m_wr + n) & 31;
    else if (m_drops < 65535) m_drops++;
`ifdef FRAME_DROP_CNT_EN
    check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int used;
    rstb        = 1'b1;
    s_valid     = 1'b0;
    s_last      = 1'b0;
    s_data      = '0;
    rd_free_ptr = '0;
    rdy_auto    = 1'b1;
    gaps        = 1'b0;

    do_reset();
    clear_caps();

    // 3-word frame, then a 1-word frame starting at the committed pointer
    run_frame(3, 32'hA1);
    run_frame(1, 32'h0);

    // Over-length frame dropped, next frame reuses address 0
    do_reset();
    run_frame(9, 32'h0);
    run_frame(2, 32'h0);

    // Frame wrapping the end of the buffer
    do_reset();
    run_frame(8, 32'h0);
    run_frame(6, 32'h0);
    m_rd = 6;
    rd_free_ptr = 5'd6;
    run_frame(4, 32'h0);

    // Full buffer drops; a release makes room again
    do_reset();
    run_frame(8, 32'h0);
    run_frame(8, 32'h0);
    run_frame(1, 32'h0);
    m_rd = 2;
    rd_free_ptr = 5'd2;
    run_frame(2, 32'h0);

    // Descriptor back-pressure in COMMIT
    do_reset();
    clear_caps();
    rdy_auto   = 1'b0;
    desc_ready = 1'b0;
    send_beat(32'h11, 1'b0);
    send_beat(32'h22, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check("hold_s_ready", 64'(s_ready), 64'd0);
      check("hold_desc_valid", 64'(desc_valid), 64'd1);
      check("hold_desc_addr", 64'(desc_addr), 64'd0);
      check("hold_desc_len", 64'(desc_len), 64'd2);
      @(posedge clka);
      #1;
    end
    desc_ready = 1'b1;
    @(posedge clka);
    #1;
    desc_ready = 1'b0;
    check("commit_desc_valid", 64'(desc_valid), 64'd0);
    check("commit_s_ready", 64'(s_ready), 64'd1);
    check("commit_desc_count", 64'(cap_daddr.size()), 64'd1);
    check("commit_wr_count", 64'(cap_addr.size()), 64'd2);
    m_wr = 2;
    rdy_auto = 1'b1;
    run_frame(1, 32'h0);

    // Reset in the middle of a frame
    do_reset();
    clear_caps();
    send_beat(32'h5, 1'b0);
    send_beat(32'h6, 1'b0);
    do_reset();
    check("midrst_no_desc", 64'(cap_daddr.size()), 64'd0);
    run_frame(1, 32'h0);

    // Randomized frames with random reader releases and stream gaps
    do_reset();
    gaps = 1'b1;
    for (int f = 0; f < 40; f++) begin
      used = (m_wr - m_rd) & 31;
      if ($urandom_range(0, 2) == 0) begin
        m_rd = (m_rd + $urandom_range(0, used)) & 31;
        rd_free_ptr = 5'(m_rd);
      end
      run_frame($urandom_range(1, 10), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
